vx_warp_sched_rr: RTL and testbench

Parametrised next-generation warp scheduler for the core front end: keeps per-warp active/stall state, thread masks and PCs, and issues one warp per cycle to fetch. Replaces fixed lowest-index selection with round-robin fairness. Adds per-warp in-flight credit throttling, so no warp exceeds MAX_PENDING uncommitted instructions. Sits between the warp-control/branch/commit feedback paths and the fetch stage.

---
 rtl/vx_sched_pkg.sv | 20 ++
 rtl/vx_sched_rr_select.sv | 36 +++
 rtl/vx_warp_sched_rr.sv | 191 +++++++++++++++++++
 tb/tb_vx_warp_sched_rr.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_sched_pkg.sv
// Core configuration and shared types for the round-robin warp scheduler.
// Widths of the issue record follow the core configuration below.
package vx_sched_pkg;

    localparam int NUM_WARPS   = 8;
    localparam int NUM_THREADS = 4;
    localparam int XLEN        = 32;
    localparam int PC_STEP     = 4;
    localparam int MAX_PENDING = 15;

    localparam int NW_W  = $clog2(NUM_WARPS);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    typedef struct packed {
        logic [NW_W-1:0]        wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [XLEN-1:0]        pc;
    } sched_out_t;

endpackage

// File: rtl/vx_sched_rr_select.sv
// Round-robin picker: first set bit of ready at or after ptr, wrapping.
// Purely combinational (0 cycles); no flow control of its own.
module vx_sched_rr_select #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] ready,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_wid
);

    logic [N-1:0] rot;
    logic [W-1:0] idx;

    // Rotate so ptr lands at bit 0; the W-bit index sum wraps because N is a power of two.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = ready[W'(i) + ptr];
        end
    end

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = W'(i);
            end
        end
    end

    assign grant_valid = |ready;
    assign grant_wid   = idx + ptr;

endmodule

// File: rtl/vx_warp_sched_rr.sv
// Round-robin warp scheduler with per-warp in-flight credit limit; VX_SCHED_PERF_EN adds perf counters.
// Latency: a warp becoming ready is presented on sched_* one cycle later.
// Backpressure: sched_* holds while sched_valid & ~sched_ready; no new warp is picked until accepted.
module vx_warp_sched_rr
    import vx_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [XLEN-1:0]        startup_pc,
    input  logic                   spawn_valid,
    input  logic [NUM_WARPS-1:0]   spawn_wmask,
    input  logic [XLEN-1:0]        spawn_pc,
    input  logic                   tmc_valid,
    input  logic [NW_W-1:0]        tmc_wid,
    input  logic [NUM_THREADS-1:0] tmc_tmask,
    input  logic                   unlock_valid,
    input  logic [NW_W-1:0]        unlock_wid,
    input  logic                   branch_valid,
    input  logic [NW_W-1:0]        branch_wid,
    input  logic                   branch_taken,
    input  logic [XLEN-1:0]        branch_dest,
    input  logic                   commit_valid,
    input  logic [NW_W-1:0]        commit_wid,
    output logic                   sched_valid,
    input  logic                   sched_ready,
    output logic [NW_W-1:0]        sched_wid,
    output logic [NUM_THREADS-1:0] sched_tmask,
    output logic [XLEN-1:0]        sched_pc,
`ifdef VX_SCHED_PERF_EN
    output logic                   busy,
    output logic [63:0]            perf_idles,
    output logic [63:0]            perf_stalls
`else
    output logic                   busy
`endif
);

    logic [NUM_WARPS-1:0]   active;
    logic [NUM_WARPS-1:0]   stalled;
    logic [NUM_WARPS-1:0]   ready;
    logic [NUM_THREADS-1:0] tmask   [NUM_WARPS];
    logic [XLEN-1:0]        pc      [NUM_WARPS];
    logic [CNT_W-1:0]       pending [NUM_WARPS];

    logic [NUM_WARPS-1:0]   sel_oh;
    logic [NUM_WARPS-1:0]   cmt_oh;
    logic [NUM_WARPS-1:0]   pend_nz;

    logic [NW_W-1:0]        rr_ptr;
    logic [NW_W-1:0]        grant_wid;
    logic                   grant_valid;
    logic                   load_en;
    logic                   fire;
    logic                   out_vld;
    logic                   busy_q;
    sched_out_t             out_q;

    always_comb begin
        ready   = '0;
        sel_oh  = '0;
        cmt_oh  = '0;
        pend_nz = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            ready[w]   = active[w] & ~stalled[w] & (pending[w] != CNT_W'(MAX_PENDING));
            sel_oh[w]  = fire & (grant_wid == NW_W'(w));
            cmt_oh[w]  = commit_valid & (commit_wid == NW_W'(w)) & (pending[w] != '0);
            pend_nz[w] = (pending[w] != '0);
        end
    end

    vx_sched_rr_select #(
        .N (NUM_WARPS),
        .W (NW_W)
    ) u_select (
        .ready       (ready),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_wid   (grant_wid)
    );

    assign load_en = ~out_vld | sched_ready;
    assign fire    = load_en & grant_valid;

    // Later statements override earlier ones: spawn, tmc, branch, unlock, then select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active  <= NUM_WARPS'(1);
            stalled <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                tmask[w] <= (w == 0) ? NUM_THREADS'(1) : '0;
                pc[w]    <= (w == 0) ? startup_pc : '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (spawn_valid && spawn_wmask[w]) begin
                    active[w] <= 1'b1;
                    tmask[w]  <= NUM_THREADS'(1);
                    pc[w]     <= spawn_pc;
                end
            end
            if (tmc_valid) begin
                active[tmc_wid]  <= (tmc_tmask != '0);
                tmask[tmc_wid]   <= tmc_tmask;
                stalled[tmc_wid] <= 1'b0;
            end
            if (branch_valid) begin
                if (branch_taken) begin
                    pc[branch_wid] <= branch_dest;
                end
                stalled[branch_wid] <= 1'b0;
            end
            if (unlock_valid) begin
                stalled[unlock_wid] <= 1'b0;
            end
            if (fire) begin
                stalled[grant_wid] <= 1'b1;
                pc[grant_wid]      <= pc[grant_wid] + XLEN'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pending[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (sel_oh[w] && !cmt_oh[w] && pending[w] != CNT_W'(MAX_PENDING)) begin
                    pending[w] <= pending[w] + CNT_W'(1);
                end else if (!sel_oh[w] && cmt_oh[w]) begin
                    pending[w] <= pending[w] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld <= 1'b0;
            out_q   <= '0;
            rr_ptr  <= '0;
        end else if (load_en) begin
            out_vld <= grant_valid;
            if (grant_valid) begin
                out_q.wid   <= grant_wid;
                out_q.tmask <= tmask[grant_wid];
                out_q.pc    <= pc[grant_wid];
                rr_ptr      <= grant_wid + NW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (|active) | (|pend_nz);
        end
    end

`ifdef VX_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_idles  <= '0;
            perf_stalls <= '0;
        end else begin
            if (load_en && !grant_valid) begin
                perf_idles <= perf_idles + 64'd1;
            end
            if (out_vld && !sched_ready) begin
                perf_stalls <= perf_stalls + 64'd1;
            end
        end
    end
`endif

    // A commit with nothing in flight means the commit path lost track of this warp.
    property p_commit_has_pending;
        @(posedge clk) disable iff (!reset_n)
        commit_valid |-> (pending[commit_wid] != '0);
    endproperty
    assert property (p_commit_has_pending);

    assign sched_valid = out_vld;
    assign sched_wid   = out_q.wid;
    assign sched_tmask = out_q.tmask;
    assign sched_pc    = out_q.pc;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vx_warp_sched_rr.sv
// Directed bench for vx_warp_sched_rr: reset, round-robin order, backpressure,
// credit limit, branch/tmc interaction and asynchronous reset mid-issue.
module tb_vx_warp_sched_rr;
    import vx_sched_pkg::*;

    logic                   clk;
    logic                   reset_n;
    logic [XLEN-1:0]        startup_pc;
    logic                   spawn_valid;
    logic [NUM_WARPS-1:0]   spawn_wmask;
    logic [XLEN-1:0]        spawn_pc;
    logic                   tmc_valid;
    logic [NW_W-1:0]        tmc_wid;
    logic [NUM_THREADS-1:0] tmc_tmask;
    logic                   unlock_valid;
    logic [NW_W-1:0]        unlock_wid;
    logic                   branch_valid;
    logic [NW_W-1:0]        branch_wid;
    logic                   branch_taken;
    logic [XLEN-1:0]        branch_dest;
    logic                   commit_valid;
    logic [NW_W-1:0]        commit_wid;
    logic                   sched_valid;
    logic                   sched_ready;
    logic [NW_W-1:0]        sched_wid;
    logic [NUM_THREADS-1:0] sched_tmask;
    logic [XLEN-1:0]        sched_pc;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;

    vx_warp_sched_rr dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .startup_pc   (startup_pc),
        .spawn_valid  (spawn_valid),
        .spawn_wmask  (spawn_wmask),
        .spawn_pc     (spawn_pc),
        .tmc_valid    (tmc_valid),
        .tmc_wid      (tmc_wid),
        .tmc_tmask    (tmc_tmask),
        .unlock_valid (unlock_valid),
        .unlock_wid   (unlock_wid),
        .branch_valid (branch_valid),
        .branch_wid   (branch_wid),
        .branch_taken (branch_taken),
        .branch_dest  (branch_dest),
        .commit_valid (commit_valid),
        .commit_wid   (commit_wid),
        .sched_valid  (sched_valid),
        .sched_ready  (sched_ready),
        .sched_wid    (sched_wid),
        .sched_tmask  (sched_tmask),
        .sched_pc     (sched_pc),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        spawn_valid  = 1'b0;
        tmc_valid    = 1'b0;
        unlock_valid = 1'b0;
        branch_valid = 1'b0;
        branch_taken = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        startup_pc  = 32'h8000_0000;
        sched_ready = 1'b1;
        spawn_wmask = '0;
        spawn_pc    = '0;
        tmc_wid     = '0;
        tmc_tmask   = '0;
        unlock_wid  = '0;
        branch_wid  = '0;
        branch_dest = '0;
        commit_wid  = '0;
        clear_pulses();
        tick(); tick(); tick();
        n_checks++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", sched_valid); end
        n_checks++; if (sched_wid !== 3'd0) begin n_fail++; $display("FAIL rst_wid: got %0d want 0", sched_wid); end
        n_checks++; if (sched_tmask !== 4'd0) begin n_fail++; $display("FAIL rst_tmask: got %b want 0000", sched_tmask); end
        n_checks++; if (sched_pc !== 32'd0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", sched_pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        tick();
        n_checks++; if (sched_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", sched_valid); end
        n_checks++; if (sched_wid !== 3'd0) begin n_fail++; $display("FAIL first_wid: got %0d want 0", sched_wid); end
        n_checks++; if (sched_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL first_pc: got %h want 80000000", sched_pc); end
        n_checks++; if (sched_tmask !== 4'b0001) begin n_fail++; $display("FAIL first_tmask: got %b want 0001", sched_tmask); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL stalled_no_issue: cycle %0d got %b want 0", i, sched_valid); end
        end
        unlock_valid = 1'b1;
        unlock_wid   = 3'd0;
        tick();
        clear_pulses();
        n_checks++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL unlock_lat: got %b want 0", sched_valid); end
        tick();
        n_checks++; if (sched_valid !== 1'b1 || sched_wid !== 3'd0) begin n_fail++; $display("FAIL unlock_reissue: got v=%b w=%0d want v=1 w=0", sched_valid, sched_wid); end
        n_checks++; if (sched_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL unlock_pc: got %h want 80000004", sched_pc); end
    endtask

    task automatic test_round_robin();
        logic [NW_W-1:0] exp_wid;
        logic [XLEN-1:0] exp_pc;
        spawn_valid  = 1'b1;
        spawn_wmask  = 8'hFF;
        spawn_pc     = 32'h100;
        unlock_valid = 1'b1;
        unlock_wid   = 3'd0;
        tick();
        clear_pulses();
        n_checks++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL spawn_lat: got %b want 0", sched_valid); end
        tick();
        for (int k = 0; k < 9; k++) begin
            exp_wid = NW_W'((k + 1) % NUM_WARPS);
            exp_pc  = (k == 8) ? 32'h104 : 32'h100;
            n_checks++; if (sched_valid !== 1'b1 || sched_wid !== exp_wid) begin n_fail++; $display("FAIL rr_order: step %0d got v=%b w=%0d want v=1 w=%0d", k, sched_valid, sched_wid, exp_wid); end
            n_checks++; if (sched_pc !== exp_pc) begin n_fail++; $display("FAIL rr_pc: step %0d got %h want %h", k, sched_pc, exp_pc); end
            n_checks++; if (sched_tmask !== 4'b0001) begin n_fail++; $display("FAIL rr_tmask: step %0d got %b want 0001", k, sched_tmask); end
            unlock_valid = 1'b1;
            unlock_wid   = exp_wid;
            tick();
            clear_pulses();
        end
    endtask

    task automatic test_backpressure();
        n_checks++; if (sched_valid !== 1'b1 || sched_wid !== 3'd2 || sched_pc !== 32'h104) begin n_fail++; $display("FAIL bp_start: got v=%b w=%0d pc=%h want v=1 w=2 pc=104", sched_valid, sched_wid, sched_pc); end
        sched_ready  = 1'b0;
        commit_valid = 1'b1;
        commit_wid   = 3'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            clear_pulses();
            n_checks++; if (sched_valid !== 1'b1 || sched_wid !== 3'd2 || sched_pc !== 32'h104) begin n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b w=%0d pc=%h want v=1 w=2 pc=104", i, sched_valid, sched_wid, sched_pc); end
        end
        sched_ready = 1'b1;
        tick();
        n_checks++; if (sched_valid !== 1'b1 || sched_wid !== 3'd3) begin n_fail++; $display("FAIL bp_release: got v=%b w=%0d want v=1 w=3", sched_valid, sched_wid); end
        n_checks++; if (sched_pc !== 32'h104) begin n_fail++; $display("FAIL bp_other_pc: got %h want 104", sched_pc); end
    endtask

    task automatic test_credit_limit();
        int cnt;
        cnt          = 1;
        unlock_valid = 1'b1;
        unlock_wid   = 3'd3;
        for (int cyc = 0; cyc < 100 && cnt < 15; cyc++) begin
            tick();
            clear_pulses();
            if (sched_valid && sched_wid == 3'd3) begin
                cnt++;
                n_checks++; if (sched_pc !== 32'h104 + 32'(4 * (cnt - 1))) begin n_fail++; $display("FAIL credit_pc: issue %0d got %h want %h", cnt, sched_pc, 32'h104 + 32'(4 * (cnt - 1))); end
                unlock_valid = 1'b1;
                unlock_wid   = 3'd3;
            end
        end
        n_checks++; if (cnt != 15) begin n_fail++; $display("FAIL credit_timeout: got %0d issues want 15", cnt); end
        for (int i = 0; i < 4; i++) begin
            tick();
            clear_pulses();
            n_checks++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL credit_block: cycle %0d got v=%b w=%0d want v=0", i, sched_valid, sched_wid); end
        end
        commit_valid = 1'b1;
        commit_wid   = 3'd3;
        tick();
        clear_pulses();
        n_checks++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL credit_commit_lat: got %b want 0", sched_valid); end
        tick();
        n_checks++; if (sched_valid !== 1'b1 || sched_wid !== 3'd3) begin n_fail++; $display("FAIL credit_resume: got v=%b w=%0d want v=1 w=3", sched_valid, sched_wid); end
        n_checks++; if (sched_pc !== 32'h140) begin n_fail++; $display("FAIL credit_resume_pc: got %h want 140", sched_pc); end
    endtask

    task automatic test_branch_tmc();
        int  ul [7] = '{0, 1, 2, 4, 5, 6, 7};
        bit  seen2;
        branch_valid = 1'b1;
        branch_wid   = 3'd2;
        branch_taken = 1'b1;
        branch_dest  = 32'h2000;
        tmc_valid    = 1'b1;
        tmc_wid      = 3'd5;
        tmc_tmask    = 4'b0000;
        tick();
        clear_pulses();
        n_checks++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL br_lat: got %b want 0", sched_valid); end
        tick();
        n_checks++; if (sched_valid !== 1'b1 || sched_wid !== 3'd2) begin n_fail++; $display("FAIL br_issue: got v=%b w=%0d want v=1 w=2", sched_valid, sched_wid); end
        n_checks++; if (sched_pc !== 32'h2000) begin n_fail++; $display("FAIL br_pc: got %h want 2000", sched_pc); end
        n_checks++; if (sched_tmask !== 4'b0001) begin n_fail++; $display("FAIL br_tmask: got %b want 0001", sched_tmask); end
        seen2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            unlock_valid = 1'b1;
            unlock_wid   = NW_W'(ul[i % 7]);
            tick();
            clear_pulses();
            n_checks++; if (sched_valid === 1'b1 && sched_wid === 3'd5) begin n_fail++; $display("FAIL tmc_dead: cycle %0d got w=5 want not 5", i); end
            if (!seen2 && sched_valid && sched_wid == 3'd2) begin
                seen2 = 1'b1;
                n_checks++; if (sched_pc !== 32'h2004) begin n_fail++; $display("FAIL br_next_pc: got %h want 2004", sched_pc); end
            end
        end
        n_checks++; if (seen2 !== 1'b1) begin n_fail++; $display("FAIL br_reissue_timeout: got %b want 1", seen2); end
    endtask

    task automatic test_async_reset();
        int ul [7] = '{0, 1, 2, 4, 5, 6, 7};
        sched_ready = 1'b0;
        for (int i = 0; i < 14 && !sched_valid; i++) begin
            unlock_valid = 1'b1;
            unlock_wid   = NW_W'(ul[i % 7]);
            tick();
            clear_pulses();
        end
        clear_pulses();
        n_checks++; if (sched_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b want 1", sched_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", sched_valid); end
        n_checks++; if (sched_wid !== 3'd0 || sched_tmask !== 4'd0) begin n_fail++; $display("FAIL arst_wid_tmask: got w=%0d t=%b want w=0 t=0000", sched_wid, sched_tmask); end
        n_checks++; if (sched_pc !== 32'd0) begin n_fail++; $display("FAIL arst_pc: got %h want 0", sched_pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
        tick();
        sched_ready = 1'b1;
        reset_n     = 1'b1;
        tick();
        n_checks++; if (sched_valid !== 1'b1 || sched_wid !== 3'd0) begin n_fail++; $display("FAIL arst_restart: got v=%b w=%0d want v=1 w=0", sched_valid, sched_wid); end
        n_checks++; if (sched_pc !== 32'h8000_0000 || sched_tmask !== 4'b0001) begin n_fail++; $display("FAIL arst_restart_pc: got pc=%h t=%b want pc=80000000 t=0001", sched_pc, sched_tmask); end
        tick();
        n_checks++; if (sched_valid !== 1'b0) begin n_fail++; $display("FAIL arst_only_w0: got v=%b w=%0d want v=0", sched_valid, sched_wid); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_credit_limit();
        test_branch_tmc();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
